mips32_prog_loader: RTL and testbench

//  Upstream feeder for mips32_core: accepts a program image as a 32-bit valid/ready word stream and

---
 rtl/mips32_pkg.sv | 22 ++
 rtl/mips32_loader_csum.sv | 39 +++
 rtl/mips32_prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_mips32_prog_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 core and its program loader:
// loader FSM state encoding, program-header field positions and Mem depth.
package mips32_pkg;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HDR  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_REL  = 3'd4,
    LD_RUN  = 3'd5,
    LD_ERR  = 3'd6
  } ld_state_e;

  // Header word: payload word count lives in the upper half, base address in the low bits.
  localparam int HDR_CNT_MSB = 31;
  localparam int HDR_CNT_LSB = 16;

  // Unified Mem depth in words for the default 10-bit word address.
  localparam int MEM_DEPTH = 1024;

endpackage

// File: rtl/mips32_loader_csum.sv
// Running sum of payload words (mod 2**DATA_W) for the program loader.
// Only instantiated when MIPS_LOADER_CHECKSUM_EN is defined.
module mips32_loader_csum #(
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc,
  input  logic [DATA_W-1:0] data,
  output logic              match
);

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;

  // Clear at the start of each image, otherwise add every accepted payload word.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (acc) begin
      sum_d = sum_q + data;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk1) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  // The trailing checksum word is compared against the sum of the whole payload.
  assign match = (data == sum_q);

endmodule

// File: rtl/mips32_prog_loader.sv
// Program loader for mips32_core: takes a header/payload stream, writes the payload
// into Mem through a registered write port, then loads PC and releases the core.
// Optional feature: define MIPS_LOADER_CHECKSUM_EN to require a trailing checksum word.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_halt,
  output logic              core_pc_load,
  output logic [31:0]       core_pc_value,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = HDR_CNT_MSB - HDR_CNT_LSB + 1;
  // One extra bit so base + N is checked against the Mem depth without wrapping.
  localparam int CHK_W = CNT_W + 1;
  localparam logic [CHK_W-1:0] DEPTH = CHK_W'(2 ** ADDR_W);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              core_halt_q, core_halt_d;
  logic              pc_load_q, pc_load_d;
  logic [31:0]       pc_value_q, pc_value_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [CNT_W-1:0]  hdr_cnt;
  logic [ADDR_W-1:0] hdr_base;
  logic [CHK_W-1:0]  hdr_end;
  logic              hdr_bad;

  assign xfer     = s_valid & s_ready_q;
  assign cnt_nxt  = cnt_q + CNT_W'(1);
  assign hdr_cnt  = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_base = s_data[ADDR_W-1:0];
  assign hdr_end  = CHK_W'(hdr_base) + CHK_W'(hdr_cnt);
  assign hdr_bad  = (hdr_cnt == '0) || (hdr_end > DEPTH);

`ifdef MIPS_LOADER_CHECKSUM_EN
  logic csum_clr;
  logic csum_acc;
  logic csum_match;

  assign csum_clr = (state_q == LD_IDLE);
  assign csum_acc = (state_q == LD_DATA) && xfer;

  mips32_loader_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk1  (clk1),
    .rst   (rst),
    .clr   (csum_clr),
    .acc   (csum_acc),
    .data  (s_data),
    .match (csum_match)
  );
`endif

  // Next-state and next-output logic; every output is a decode of the next state so it is registered.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_value_d  = pc_value_q;
    case (state_q)
      LD_IDLE: begin
        state_d = LD_HDR;
        cnt_d   = '0;
      end
      LD_HDR: begin
        if (xfer) begin
          n_d     = hdr_cnt;
          base_d  = hdr_base;
          state_d = hdr_bad ? LD_ERR : LD_DATA;
        end
      end
      LD_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + cnt_q[ADDR_W-1:0];
          mem_wdata_d = s_data;
          cnt_d       = cnt_nxt;
          if (cnt_nxt == n_q) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
            state_d = LD_CSUM;
`else
            state_d = LD_REL;
`endif
          end
        end
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      LD_CSUM: begin
        if (xfer) begin
          state_d = csum_match ? LD_REL : LD_ERR;
        end
      end
`endif
      LD_REL: begin
        state_d = LD_RUN;
      end
      LD_RUN, LD_ERR: begin
        if (reload) begin
          state_d = LD_IDLE;
        end
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase

    // The PC value is presented together with the one-cycle load pulse in REL.
    if (state_d == LD_REL) begin
      pc_value_d = 32'(base_q);
    end
    s_ready_d   = state_d inside {LD_HDR, LD_DATA, LD_CSUM};
    core_halt_d = (state_d != LD_RUN);
    pc_load_d   = (state_d == LD_REL);
    done_d      = (state_d == LD_RUN);
    err_d       = (state_d == LD_ERR);
  end

  // Control and output registers; rst aborts any load in progress.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_halt_q <= 1'b1;
      pc_load_q   <= 1'b0;
      pc_value_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_halt_q <= core_halt_d;
      pc_load_q   <= pc_load_d;
      pc_value_q  <= pc_value_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Header fields are only consulted after HDR has latched them, so they carry no reset.
  always_ff @(posedge clk1) begin
    base_q <= base_d;
    n_q    <= n_d;
  end

  assign s_ready       = s_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign core_halt     = core_halt_q;
  assign core_pc_load  = pc_load_q;
  assign core_pc_value = pc_value_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: drives header/payload images with
// random gaps and checks Mem writes, PC hand-off and error paths against a model.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              reload = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_halt;
  logic              core_pc_load;
  logic [31:0]       core_pc_value;
  logic              done;
  logic              err;

  mips32_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk1(clk1), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_halt(core_halt), .core_pc_load(core_pc_load), .core_pc_value(core_pc_value),
    .done(done), .err(err)
  );

  always #5 clk1 = ~clk1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] img [$];
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          cyc = 0;
  int          last_wr_cyc = -1;
  int          pcl_cyc = -1;
  int          run_cyc = -1;
  int unsigned pcl_cnt = 0;
  int unsigned pcl_before = 0;
  logic [31:0] pcl_val = '0;
  bit          done_prev = 1'b0;
  bit          noise_reload = 1'b0;
  bit          halt_watch = 1'b0;
  int unsigned halt_low_cnt = 0;

  // Observer standing in for the core's Mem and recording hand-off events.
  always @(negedge clk1) begin
    if (mem_we === 1'b1) begin
      tb_mem[mem_addr] = mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      last_wr_cyc = cyc;
    end
    if (core_pc_load === 1'b1) begin
      pcl_cnt++;
      pcl_val = core_pc_value;
      pcl_cyc = cyc;
    end
    if (done === 1'b1 && !done_prev) run_cyc = cyc;
    done_prev = (done === 1'b1);
    if (halt_watch && core_halt !== 1'b1 && done !== 1'b1) halt_low_cnt++;
    cyc++;
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic noise();
    return noise_reload ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Offer one word, optionally after a few idle cycles, and hold it until accepted.
  task automatic push(input logic [31:0] d, input int gap_pct);
    int k;
    int idle;
    idle = (int'($urandom_range(0, 99)) < gap_pct) ? int'($urandom_range(1, 3)) : 0;
    repeat (idle) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      reload  = noise();
      step();
    end
    s_valid = 1'b1;
    s_data  = d;
    reload  = noise();
    k = 0;
    while (s_ready !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_timeout: s_ready=%b after %0d cycles, required 1", s_ready, k);
    end
    step();
    s_valid = 1'b0;
    reload  = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic rand_img(input int unsigned n);
    img.delete();
    for (int i = 0; i < int'(n); i++) img.push_back($urandom);
  endtask

  // Sends header, payload (and checksum word when enabled), then waits for RUN or ERR.
  task automatic drive_image(input int unsigned base, input int unsigned n,
                             input bit bad_sum, input int gap_pct);
    logic [31:0] hdr;
    bit          valid_hdr;
    int          k;
    valid_hdr = (n != 0) && (base + n <= DEPTH);
    wr_addr_q.delete();
    wr_data_q.delete();
    pcl_before = pcl_cnt;
    hdr = {16'(n), 6'($urandom_range(0, 63)), 10'(base)};
    push(hdr, gap_pct);
    if (!valid_hdr) begin
      repeat (2) step();
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      push(img[i], gap_pct);
      exp_mem[(base + i) % DEPTH] = img[i];
    end
`ifdef MIPS_LOADER_CHECKSUM_EN
    begin
      logic [31:0] sum;
      sum = '0;
      foreach (img[i]) sum += img[i];
      push(bad_sum ? sum + 32'd1 : sum, gap_pct);
    end
`else
    if (bad_sum) $display("note: no checksum word in this build");
`endif
    k = 0;
    while (done !== 1'b1 && err !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    @(negedge clk1);
    #1;
    step();
  endtask

  function automatic int stream_errs(input int unsigned base);
    int e;
    e = (wr_addr_q.size() != img.size()) ? 1 : 0;
    for (int i = 0; i < wr_addr_q.size() && i < img.size(); i++)
      if (wr_addr_q[i] !== 10'((base + i) % DEPTH) || wr_data_q[i] !== img[i]) e++;
    return e;
  endfunction

  function automatic int mem_errs();
    int e;
    e = 0;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== exp_mem[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    step();
    step();
    vectors++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, core_halt, core_pc_load, core_pc_value, done, err}
        !== {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h wd=%h halt=%b pcl=%b pcv=%h done=%b err=%b, required halt=1 others 0",
               s_ready, mem_we, mem_addr, mem_wdata, core_halt, core_pc_load, core_pc_value, done, err);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_to_hdr: s_ready=%b, required 1", s_ready);
    end
  endtask

  task automatic test_spec_image();
    img.delete();
    img.push_back(32'h2019_0200);
    img.push_back(32'h2018_0300);
    img.push_back(32'h0319_1020);
    drive_image(0, 3, 1'b0, 0);
    vectors++;
    if ({done, core_halt, err, s_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL spec_run_state: done/halt/err/rdy=%b, required 1000", {done, core_halt, err, s_ready});
    end
    vectors++;
    if (pcl_cnt != pcl_before + 1 || pcl_val !== 32'd0) begin
      miscompares++;
      $display("FAIL spec_pc_load: pulses=%0d value=%h, required 1 pulse value 00000000", pcl_cnt - pcl_before, pcl_val);
    end
    vectors++;
    if (run_cyc != pcl_cyc + 1 || last_wr_cyc > pcl_cyc) begin
      miscompares++;
      $display("FAIL spec_handoff: run at %0d lastwr at %0d, required run %0d lastwr <= %0d", run_cyc, last_wr_cyc, pcl_cyc + 1, pcl_cyc);
    end
    vectors++;
    if (stream_errs(0) != 0) begin
      miscompares++;
      $display("FAIL spec_writes: %0d bad entries of %0d writes, required 0 bad of 3", stream_errs(0), wr_addr_q.size());
    end
  endtask

  task automatic test_bad_header();
    do_reload();
    vectors++;
    if (core_halt !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_halt: halt=%b done=%b, required 1 0", core_halt, done);
    end
    rand_img(2);
    drive_image(1023, 2, 1'b0, 0);
    vectors++;
    if ({err, core_halt, s_ready, done} !== 4'b1100 || wr_addr_q.size() != 0 || pcl_cnt != pcl_before) begin
      miscompares++;
      $display("FAIL overrun_hdr: err/halt/rdy/done=%b writes=%0d pcl=%0d, required 1100 0 0",
               {err, core_halt, s_ready, done}, wr_addr_q.size(), pcl_cnt - pcl_before);
    end
    do_reload();
    vectors++;
    if (err !== 1'b0 || core_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: err=%b halt=%b, required 0 1", err, core_halt);
    end
    rand_img(2);
    drive_image(1022, 2, 1'b0, 20);
    vectors++;
    if (done !== 1'b1 || pcl_val !== 32'd1022 || stream_errs(1022) != 0) begin
      miscompares++;
      $display("FAIL top_edge_image: done=%b pc=%h bad=%0d, required 1 000003fe 0", done, pcl_val, stream_errs(1022));
    end
  endtask

  task automatic test_zero_len();
    int unsigned base;
    do_reload();
    img.delete();
    base = $urandom_range(0, DEPTH - 1);
    drive_image(base, 0, 1'b0, 0);
    vectors++;
    if (err !== 1'b1 || core_halt !== 1'b1 || wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len: err=%b halt=%b writes=%0d, required 1 1 0", err, core_halt, wr_addr_q.size());
    end
    do_reload();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_reload: err=%b, required 0", err);
    end
    rand_img(4);
    base = $urandom_range(0, DEPTH - 4);
    drive_image(base, 4, 1'b0, 30);
    vectors++;
    if (done !== 1'b1 || pcl_val !== 32'(base) || stream_errs(base) != 0) begin
      miscompares++;
      $display("FAIL zero_len_recover: done=%b pc=%h bad=%0d, required 1 %h 0", done, pcl_val, stream_errs(base), base);
    end
  endtask

`ifdef MIPS_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reload();
    img.delete();
    img.push_back(32'd1);
    img.push_back(32'd11);
    drive_image(32'h23, 2, 1'b0, 0);
    vectors++;
    if (done !== 1'b1 || err !== 1'b0 || pcl_val !== 32'h23) begin
      miscompares++;
      $display("FAIL csum_good: done=%b err=%b pc=%h, required 1 0 00000023", done, err, pcl_val);
    end
    do_reload();
    drive_image(32'h23, 2, 1'b1, 0);
    vectors++;
    if (err !== 1'b1 || core_halt !== 1'b1 || pcl_cnt != pcl_before) begin
      miscompares++;
      $display("FAIL csum_bad: err=%b halt=%b pcl=%0d, required 1 1 0", err, core_halt, pcl_cnt - pcl_before);
    end
    vectors++;
    if (tb_mem[32'h23] !== 32'd1 || tb_mem[32'h24] !== 32'd11 || stream_errs(32'h23) != 0) begin
      miscompares++;
      $display("FAIL csum_bad_mem: mem23=%h mem24=%h, required 00000001 0000000b", tb_mem[32'h23], tb_mem[32'h24]);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int unsigned n;
    int unsigned base;
    noise_reload = 1'b1;
    for (int it = 0; it < 6; it++) begin
      do_reload();
      n = $urandom_range(1, 24);
      base = (it % 3 == 2) ? DEPTH - n : $urandom_range(0, DEPTH - n);
      rand_img(n);
      drive_image(base, n, 1'b0, (it % 2 == 0) ? 0 : 40);
      vectors++;
      if (done !== 1'b1 || pcl_cnt != pcl_before + 1 || pcl_val !== 32'(base)) begin
        miscompares++;
        $display("FAIL b2b_run[%0d]: done=%b pulses=%0d pc=%h, required 1 1 %h", it, done, pcl_cnt - pcl_before, pcl_val, base);
      end
      vectors++;
      if (stream_errs(base) != 0 || last_wr_cyc > pcl_cyc || run_cyc != pcl_cyc + 1) begin
        miscompares++;
        $display("FAIL b2b_writes[%0d]: bad=%0d lastwr=%0d run=%0d pcl=%0d, required 0 lastwr<=pcl run=pcl+1",
                 it, stream_errs(base), last_wr_cyc, run_cyc, pcl_cyc);
      end
    end
    noise_reload = 1'b0;
  endtask

  task automatic test_rst_mid();
    int unsigned base;
    do_reload();
    rand_img(8);
    base = $urandom_range(0, DEPTH - 8);
    wr_addr_q.delete();
    wr_data_q.delete();
    push({16'd8, 6'd0, 10'(base)}, 0);
    for (int i = 0; i < 3; i++) begin
      push(img[i], 30);
      exp_mem[base + i] = img[i];
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, core_halt, core_pc_load, core_pc_value, done, err}
        !== {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got rdy=%b we=%b a=%h wd=%h halt=%b pcl=%b pcv=%h done=%b err=%b, required halt=1 others 0",
               s_ready, mem_we, mem_addr, mem_wdata, core_halt, core_pc_load, core_pc_value, done, err);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (wr_addr_q.size() != 3 || s_ready !== 1'b1 || mem_errs() != 0) begin
      miscompares++;
      $display("FAIL rst_mid_partial: writes=%0d rdy=%b membad=%0d, required 3 1 0", wr_addr_q.size(), s_ready, mem_errs());
    end
  endtask

  task automatic test_reload_second();
    rand_img(4);
    drive_image(32'h200, 4, 1'b0, 0);
    vectors++;
    if (done !== 1'b1 || pcl_val !== 32'h200) begin
      miscompares++;
      $display("FAIL first_image: done=%b pc=%h, required 1 00000200", done, pcl_val);
    end
    do_reload();
    vectors++;
    if (core_halt !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL second_reload: halt=%b done=%b, required 1 0", core_halt, done);
    end
    halt_watch = 1'b1;
    halt_low_cnt = 0;
    rand_img(5);
    drive_image(32'h10, 5, 1'b0, 30);
    halt_watch = 1'b0;
    vectors++;
    if (done !== 1'b1 || core_pc_value !== 32'h10 || pcl_val !== 32'h10 || halt_low_cnt != 0) begin
      miscompares++;
      $display("FAIL second_image: done=%b pcv=%h pcl=%h halt_low=%0d, required 1 00000010 00000010 0",
               done, core_pc_value, pcl_val, halt_low_cnt);
    end
    vectors++;
    if (stream_errs(32'h10) != 0 || mem_errs() != 0) begin
      miscompares++;
      $display("FAIL final_mem: stream bad=%0d mem bad=%0d, required 0 0", stream_errs(32'h10), mem_errs());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = '0;
      exp_mem[i] = '0;
    end
    test_reset();
    test_spec_image();
    test_bad_header();
    test_zero_len();
`ifdef MIPS_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    test_rst_mid();
    test_reload_second();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
